// File: rtl/me_blt_ctrl.sv
// ---------------------------------------------------------------------------
// me_blt_ctrl
// Player-bullet pool manager. Owns N_BLT bullet slots (visible flag, x, y)
// that the VGA bullet address generator reads. A fire request spawns a bullet
// just ahead of the ship in the lowest free slot. Live bullets climb SPEED
// pixels every frame. A bullet is retired when it would leave the top edge,
// or when collision logic clears it.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   frame_tick  one-cycle pulse per video frame
//   fire        fire request level, sampled every cycle
//   ship_x      ship x in play-field coordinates (no 160 px screen offset)
//   ship_y      ship y
//   hit_clr     per-slot retire request from collision logic
//   me_blt_vi   slot visible flags, bit i = slot i
//   me_blt_x    packed x, slot i at [i*CW +: CW]
//   me_blt_y    packed y, same packing
//   blt_drop    one-cycle pulse when a spawn is refused because the pool is full
//
// Every output comes straight from a register. The x/y fields of an
// invisible slot keep stale values, so consumers must gate them on me_blt_vi.
// ---------------------------------------------------------------------------
module me_blt_ctrl #(
   parameter int N_BLT    = 13,
   parameter int CW       = 9,
   parameter int SPEED    = 4,
   parameter int X_OFS    = 5,
   parameter int COOLDOWN = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic                fire,
   input  logic [CW-1:0]       ship_x,
   input  logic [CW-1:0]       ship_y,
   input  logic [N_BLT-1:0]    hit_clr,
   output logic [N_BLT-1:0]    me_blt_vi,
   output logic [N_BLT*CW-1:0] me_blt_x,
   output logic [N_BLT*CW-1:0] me_blt_y,
   output logic                blt_drop
);

   localparam int IW  = (N_BLT < 2) ? 1 : $clog2(N_BLT);
   localparam int CCW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

   typedef enum logic [1:0] {
      IDLE,
      SPAWN,
      COOL
   } state_t;

   state_t         state, state_nxt;
   logic [CCW-1:0] cool_cnt, cool_nxt;
   logic           drop_nxt;
   logic           spawn_en;
   logic           free_found;
   logic [IW-1:0]  free_idx;

   // Find the lowest-numbered invisible slot. The search uses the registered
   // visible flags. A slot that is retired in the current cycle therefore
   // cannot be reused until the following cycle.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = N_BLT - 1; i >= 0; i--) begin
         if (!me_blt_vi[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   // State register, cooldown counter and drop pulse. The spawn FSM moves
   // through these steps: wait for fire, then spend one cycle placing the
   // bullet, then sit out the cooldown frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cool_cnt <= '0;
         blt_drop <= 1'b0;
      end else begin
         state    <= state_nxt;
         cool_cnt <= cool_nxt;
         blt_drop <= drop_nxt;
      end
   end

   // Next-state logic. A refused spawn (pool full) goes straight back to
   // IDLE and does not charge a cooldown. While cooling, fire is ignored
   // and is not remembered.
   always_comb begin
      state_nxt = state;
      cool_nxt  = cool_cnt;
      drop_nxt  = 1'b0;
      spawn_en  = 1'b0;
      case (state)
         IDLE: begin
            if (fire) begin
               state_nxt = SPAWN;
            end
         end
         SPAWN: begin
            if (free_found) begin
               spawn_en = 1'b1;
               if (COOLDOWN == 0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = COOL;
                  cool_nxt  = CCW'(COOLDOWN);
               end
            end else begin
               drop_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         COOL: begin
            if (frame_tick) begin
               cool_nxt = cool_cnt - CCW'(1);
               if (cool_cnt == CCW'(1)) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Per-slot update, highest priority first:
   //   1. A spawn write.
   //   2. A hit clear.
   //   3. Frame movement.
   // A freshly spawned slot therefore skips movement in its spawn cycle. A
   // bullet that cannot climb a full SPEED step is retired in place, so its
   // y value is not allowed to wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         me_blt_vi <= '0;
         me_blt_x  <= '0;
         me_blt_y  <= '0;
      end else begin
         for (int i = 0; i < N_BLT; i++) begin
            if (spawn_en && (free_idx == IW'(i))) begin
               me_blt_vi[i]          <= 1'b1;
               me_blt_x[i*CW +: CW]  <= ship_x + CW'(X_OFS);
               me_blt_y[i*CW +: CW]  <= ship_y;
            end else if (hit_clr[i]) begin
               me_blt_vi[i] <= 1'b0;
            end else if (frame_tick && me_blt_vi[i]) begin
               if (me_blt_y[i*CW +: CW] < CW'(SPEED)) begin
                  me_blt_vi[i] <= 1'b0;
               end else begin
                  me_blt_y[i*CW +: CW] <= me_blt_y[i*CW +: CW] - CW'(SPEED);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_me_blt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_me_blt_ctrl
// Directed bench for the bullet pool manager.
// The stimulus process drives inputs one clock at a time. For each clock it
// records the outputs it expects in a scoreboard queue, stamped with a cycle
// number. A separate monitor samples the DUT on the falling edge, pops every
// entry that is due, and compares the entry against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_me_blt_ctrl;

   logic          clk;
   logic          rst;
   logic          frame_tick;
   logic          fire;
   logic [8:0]    ship_x;
   logic [8:0]    ship_y;
   logic [12:0]   hit_clr;
   logic [12:0]   me_blt_vi;
   logic [116:0]  me_blt_x;
   logic [116:0]  me_blt_y;
   logic          blt_drop;

   typedef struct {
      string      name;
      int         cyc;
      logic [12:0] vi;
      int         slot;
      logic [8:0] x;
      logic [8:0] y;
      logic       drop;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_cmp;
   int   n_bad;
   bit   done;

   me_blt_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .fire       (fire),
      .ship_x     (ship_x),
      .ship_y     (ship_y),
      .hit_clr    (hit_clr),
      .me_blt_vi  (me_blt_vi),
      .me_blt_x   (me_blt_x),
      .me_blt_y   (me_blt_y),
      .blt_drop   (blt_drop)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle stamp. Expectations are tagged with this value.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Drive one clock's worth of inputs and advance past the rising edge.
   // The inputs fall back to idle once that edge has passed.
   task automatic applyStimulus(input logic f, input logic ft, input logic [12:0] hc);
      fire       = f;
      frame_tick = ft;
      hit_clr    = hc;
      @(posedge clk);
      #1;
      fire       = 1'b0;
      frame_tick = 1'b0;
      hit_clr    = '0;
   endtask

   // Record the expected outputs for the current cycle. A slot of -1 means
   // that only the visible flags and the drop pulse are checked.
   task automatic checkOutput(input string nm, input logic [12:0] vi, input int slot,
                              input logic [8:0] x, input logic [8:0] y, input logic drop);
      exp_t e;
      e.name = nm;
      e.cyc  = cyc;
      e.vi   = vi;
      e.slot = slot;
      e.x    = x;
      e.y    = y;
      e.drop = drop;
      sb.push_back(e);
   endtask

   task automatic cmpField(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Monitor. On each falling edge, pop every expectation that is due.
   // An entry whose stamp has already passed is reported as missed.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.cyc < cyc) begin
            cmpField({e.name, ".stale"}, e.cyc, cyc);
         end else begin
            cmpField({e.name, ".vi"}, int'(me_blt_vi), int'(e.vi));
            cmpField({e.name, ".drop"}, int'(blt_drop), int'(e.drop));
            if (e.slot >= 0) begin
               cmpField({e.name, ".x"}, int'(me_blt_x[e.slot*9 +: 9]), int'(e.x));
               cmpField({e.name, ".y"}, int'(me_blt_y[e.slot*9 +: 9]), int'(e.y));
            end
         end
      end
   end

   // Guard against a stuck simulation.
   initial begin
      #200000;
      if (!done) begin
         $display("[TB] FAIL watchdog actual=timeout required=finish");
         $fatal(1, "[TB] watchdog expired");
      end
   end

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 13'h0);
      rst = 1'b0;
   endtask

   initial begin
      cyc        = 0;
      n_cmp      = 0;
      n_bad      = 0;
      done       = 1'b0;
      rst        = 1'b1;
      fire       = 1'b0;
      frame_tick = 1'b0;
      hit_clr    = '0;
      ship_x     = 9'd100;
      ship_y     = 9'd200;

      // Reset state, then a single-cycle fire request that becomes visible
      // two edges later.
      doReset();
      checkOutput("reset", 13'h0000, 0, 9'd0, 9'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      checkOutput("t1_lat", 13'h0000, -1, 9'd0, 9'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      checkOutput("t1_spawn", 13'h0001, 0, 9'd105, 9'd200, 1'b0);

      // Three frames of movement. Then fire is held through the cooldown,
      // and slot 1 appears two cycles after the eighth frame.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 13'h0);
      checkOutput("t2_move", 13'h0001, 0, 9'd105, 9'd188, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 13'h0);
      checkOutput("t2_cool7", 13'h0001, 0, 9'd105, 9'd172, 1'b0);
      applyStimulus(1'b1, 1'b1, 13'h0);
      checkOutput("t2_cool8", 13'h0001, 0, 9'd105, 9'd168, 1'b0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      checkOutput("t2_wait", 13'h0001, -1, 9'd0, 9'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      checkOutput("t2_slot1", 13'h0003, 1, 9'd105, 9'd200, 1'b0);

      // Top-edge boundary: y=2 retires and holds its value. y=4 lands on 0
      // and stays visible.
      doReset();
      ship_y = 9'd6;
      applyStimulus(1'b1, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b1, 13'h0);
      checkOutput("t3_y2", 13'h0001, 0, 9'd105, 9'd2, 1'b0);
      applyStimulus(1'b0, 1'b1, 13'h0);
      checkOutput("t3_retire", 13'h0000, 0, 9'd105, 9'd2, 1'b0);
      doReset();
      ship_y = 9'd8;
      applyStimulus(1'b1, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b1, 13'h0);
      applyStimulus(1'b0, 1'b1, 13'h0);
      checkOutput("t3_y0", 13'h0001, 0, 9'd105, 9'd0, 1'b0);

      // Fill all 13 slots. Each spawn is followed by a full cooldown. Slot k
      // then sees (13-k)*8 frames, so slot 0 ends at 511-416=95.
      doReset();
      ship_y = 9'd511;
      for (int k = 0; k < 13; k++) begin
         applyStimulus(1'b1, 1'b0, 13'h0);
         applyStimulus(1'b0, 1'b0, 13'h0);
         for (int t = 0; t < 8; t++) applyStimulus(1'b0, 1'b1, 13'h0);
      end
      checkOutput("t4_full", 13'h1FFF, 0, 9'd105, 9'd95, 1'b0);
      checkOutput("t4_full12", 13'h1FFF, 12, 9'd105, 9'd479, 1'b0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      checkOutput("t4_drop", 13'h1FFF, -1, 9'd0, 9'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 13'h0);
      checkOutput("t4_drop_end", 13'h1FFF, -1, 9'd0, 9'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      checkOutput("t4_nocool", 13'h1FFF, -1, 9'd0, 9'd0, 1'b1);

      // A hit clear and a frame tick in the same cycle. Slot 3 is hit and
      // holds y=511-320=191. The other slots move up.
      applyStimulus(1'b0, 1'b1, 13'h0008);
      checkOutput("t5_hit3", 13'h1FF7, 3, 9'd105, 9'd191, 1'b0);
      checkOutput("t5_move0", 13'h1FF7, 0, 9'd105, 9'd91, 1'b0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      checkOutput("t5_respawn3", 13'h1FFF, 3, 9'd105, 9'd511, 1'b0);

      // A slot cleared in the SPAWN cycle cannot be picked that same cycle.
      for (int t = 0; t < 8; t++) applyStimulus(1'b0, 1'b1, 13'h0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0001);
      checkOutput("t5_sameclr", 13'h1FFE, -1, 9'd0, 9'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      checkOutput("t5_reuse0", 13'h1FFF, 0, 9'd105, 9'd511, 1'b0);

      // Reset while cooling wins over fire and frame_tick. The next fire
      // request is then serviced without any cooldown wait.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 13'h0);
      rst = 1'b0;
      checkOutput("t6_rst", 13'h0000, 0, 9'd0, 9'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 13'h0);
      checkOutput("t6_lat", 13'h0000, -1, 9'd0, 9'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      checkOutput("t6_spawn", 13'h0001, 0, 9'd105, 9'd511, 1'b0);

      applyStimulus(1'b0, 1'b0, 13'h0);
      applyStimulus(1'b0, 1'b0, 13'h0);
      cmpField("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      done = 1'b1;
      $finish;
   end

endmodule
